universal_shift_reg: RTL and testbench

Parametrised WIDTH-bit register bank. It is the clocked, multi-mode successor to the team's single-bit D latch with clear. One edge-triggered register supports hold, parallel load, logical/arithmetic shift, rotate and clear, with true and complementary outputs (Q/Qbar). A shift-count tracker gives serialiser/deserialiser users a "word done" pulse. It sits between datapath blocks and serial interfaces.

---
 rtl/universal_shift_reg.sv | 133 +++++++++++++
 tb/tb_universal_shift_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
// WIDTH-bit register bank with hold, parallel load, logical and arithmetic
// shifts, rotates and a functional clear. A saturating shift counter reports
// how many shifts have happened since the last load/clear/reset. It emits a
// one-cycle word_done pulse when the counter first reaches WIDTH.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides E and mode)
//   E          enable; when low, register and counter hold
//   mode       operation select:
//                000 hold, 001 SHR, 010 SHL, 011 ROR, 100 ROL,
//                101 LOAD, 110 SAR, 111 CLEAR
//   D          parallel load data
//   sin        serial input for logical shifts
//   Q          register contents
//   Qbar       bitwise complement of Q
//   sout       bit shifted out on the most recent shift (registered)
//   shift_cnt  shifts since last load/clear/reset, saturating at WIDTH
//   word_done  one-cycle pulse after shift_cnt reaches WIDTH

module universal_shift_reg #(
    parameter int                     WIDTH     = 8,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0,
    parameter int                     CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 E,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     D,
    input  logic                 sin,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Qbar,
    output logic                 sout,
    output logic [CNT_W-1:0]     shift_cnt,
    output logic                 word_done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_SAR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             is_shift;
    logic             clr_cnt;

    // Next register value and shifted-out bit for the selected mode.
    always_comb begin
        q_nxt    = Q;
        sout_nxt = sout;
        is_shift = 1'b0;
        clr_cnt  = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_nxt    = {sin, Q[WIDTH-1:1]};
                sout_nxt = Q[0];
                is_shift = 1'b1;
            end
            MODE_SHL: begin
                q_nxt    = {Q[WIDTH-2:0], sin};
                sout_nxt = Q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_nxt    = {Q[0], Q[WIDTH-1:1]};
                sout_nxt = Q[0];
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_nxt    = {Q[WIDTH-2:0], Q[WIDTH-1]};
                sout_nxt = Q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt   = D;
                clr_cnt = 1'b1;
            end
            MODE_SAR: begin
                q_nxt    = {Q[WIDTH-1], Q[WIDTH-1:1]};
                sout_nxt = Q[0];
                is_shift = 1'b1;
            end
            MODE_CLEAR: begin
                q_nxt    = '0;
                sout_nxt = 1'b0;
                clr_cnt  = 1'b1;
            end
            MODE_HOLD: begin
                q_nxt = Q;
            end
            // Unknown mode values fall back to hold.
            default: begin
                q_nxt = Q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Q         <= RESET_VAL;
            sout      <= 1'b0;
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else if (!E) begin
            word_done <= 1'b0;
        end else begin
            Q         <= q_nxt;
            sout      <= sout_nxt;
            word_done <= 1'b0;
            if (clr_cnt) begin
                shift_cnt <= '0;
            end else if (is_shift && shift_cnt != CNT_MAX) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
                // Pulse only on the LAST -> MAX transition, so saturation
                // never re-fires it.
                word_done <= (shift_cnt == CNT_LAST);
            end
        end
    end

    assign Qbar = ~Q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// A reference model computes expected outputs from integer arithmetic and is
// compared on every falling edge; literal checks pin specific scenarios.

module tb_universal_shift_reg;

    localparam int W = 8;
    localparam logic [W-1:0] RV = 8'hA5;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          E = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  D = '0;
    logic          sin = 1'b0;
    logic [W-1:0]  Q;
    logic [W-1:0]  Qbar;
    logic          sout;
    logic [CW-1:0] shift_cnt;
    logic          word_done;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .E(E), .mode(mode), .D(D), .sin(sin),
        .Q(Q), .Qbar(Qbar), .sout(sout), .shift_cnt(shift_cnt),
        .word_done(word_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_q = 0;
    int m_sout = 0;
    int m_cnt = 0;
    int m_wd = 0;
    bit model_valid = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int md, input int d, input bit s);
        int top;
        if (r) begin
            m_q = RV; m_sout = 0; m_cnt = 0; m_wd = 0;
            return;
        end
        m_wd = 0;
        if (!e) return;
        top = (m_q >> (W - 1)) & 1;
        case (md)
            1: begin m_sout = m_q % 2; m_q = (m_q / 2) + s * (1 << (W - 1)); end
            2: begin m_sout = top; m_q = ((m_q * 2) % (1 << W)) + s; end
            3: begin m_sout = m_q % 2; m_q = (m_q / 2) + (m_q % 2) * (1 << (W - 1)); end
            4: begin m_sout = top; m_q = ((m_q * 2) % (1 << W)) + top; end
            5: begin m_q = d; m_cnt = 0; end
            6: begin m_sout = m_q % 2; m_q = (m_q / 2) + top * (1 << (W - 1)); end
            7: begin m_q = 0; m_sout = 0; m_cnt = 0; end
            default: ;
        endcase
        if (md inside {1, 2, 3, 4, 6}) begin
            if (m_cnt == W - 1) m_wd = 1;
            if (m_cnt < W) m_cnt++;
        end
    endtask

    // Apply one cycle of inputs, advance the model, settle just after the edge.
    task automatic step(input bit r, input bit e, input int md, input int d, input bit s);
        rst = r; E = e; mode = md[2:0]; D = d[W-1:0]; sin = s;
        @(posedge clk);
        model_step(r, e, md, d, s);
        if (r) model_valid = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_q", Q, m_q);
            chk("cyc_qbar", Qbar, (~m_q) & ((1 << W) - 1));
            chk("cyc_sout", sout, m_sout);
            chk("cyc_cnt", shift_cnt, m_cnt);
            chk("cyc_word_done", word_done, m_wd);
        end
    end

    initial begin
        automatic int exp_sout[8] = '{1, 1, 0, 0, 0, 0, 1, 1};

        // reset
        step(1, 0, 0, 0, 0);
        chk("rst_q", Q, 8'hA5);
        chk("rst_qbar", Qbar, 8'h5A);
        chk("rst_sout", sout, 0);
        chk("rst_cnt", shift_cnt, 0);
        chk("rst_wd", word_done, 0);

        // load then three SHR with sin=1
        step(0, 1, 5, 8'b1001_0110, 0);
        step(0, 1, 1, 0, 1);
        chk("shr1_sout", sout, 0);
        step(0, 1, 1, 0, 1);
        chk("shr2_sout", sout, 1);
        step(0, 1, 1, 0, 1);
        chk("shr3_q", Q, 8'b1111_0010);
        chk("shr3_sout", sout, 1);
        chk("shr3_cnt", shift_cnt, 3);

        // serialise C3 MSB-first
        step(0, 1, 5, 8'hC3, 0);
        chk("load_cnt", shift_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2, 0, 0);
            chk($sformatf("ser_sout%0d", i), sout, exp_sout[i]);
            if (i == 6) chk("ser_wd_early", word_done, 0);
        end
        chk("ser_q", Q, 8'h00);
        chk("ser_wd", word_done, 1);
        chk("ser_cnt", shift_cnt, 8);
        step(0, 1, 2, 0, 0);
        chk("sat_cnt", shift_cnt, 8);
        chk("sat_wd", word_done, 0);

        // rotate and arithmetic shift
        step(0, 1, 5, 8'h81, 0);
        step(0, 1, 4, 0, 0);
        chk("rol_q", Q, 8'h03);
        step(0, 1, 3, 0, 0);
        chk("ror_q", Q, 8'h81);
        step(0, 1, 6, 0, 0);
        chk("sar1_q", Q, 8'hC0);
        chk("sar1_sout", sout, 1);
        step(0, 1, 6, 0, 1);
        chk("sar2_q", Q, 8'hE0);
        chk("sar2_sout", sout, 0);

        // enable low holds, then clear
        step(0, 1, 5, 8'hFF, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);
        chk("en_q", Q, 8'hFF);
        chk("en_cnt", shift_cnt, 0);
        step(0, 1, 1, 0, 0);
        chk("en_shift_sout", sout, 1);
        step(0, 1, 7, 0, 0);
        chk("clr_q", Q, 8'h00);
        chk("clr_qbar", Qbar, 8'hFF);
        chk("clr_sout", sout, 0);
        chk("clr_cnt", shift_cnt, 0);

        // reset mid-stream wins over shift
        step(0, 1, 5, 8'h5C, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2, 0, 1);
        chk("mid_cnt5", shift_cnt, 5);
        step(1, 1, 2, 0, 1);
        chk("mid_rst_q", Q, 8'hA5);
        chk("mid_rst_cnt", shift_cnt, 0);
        chk("mid_rst_wd", word_done, 0);

        // a full word after reset pulses again (model-checked per cycle)
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0, i % 2);
        step(0, 1, 0, 0, 0);
        chk("hold_cnt", shift_cnt, 8);

        model_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
